// File: rtl/usb_rx_line_decoder.sv
// usb_rx_line_decoder
// Full-speed USB receive front end: 8x oversampled D+/D-, phase tracking, NRZI
// decode, bit-unstuffing, SYNC/EOP detection and LSB-first byte delivery.
// Optional feature macro: USB_RX_CRC16_EN adds a CRC16 checker and the crc_ok port.
module usb_rx_line_decoder #(
   parameter int SAMPLES_PER_BIT = 8,
   parameter int SAMPLE_POINT    = 3,
   parameter int STUFF_LIMIT     = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       d_plus_in,
   input  logic       d_minus_in,
   input  logic       rx_enable,
   output logic [7:0] rcv_data,
   output logic       rcv_valid,
   output logic       rcv_active,
   output logic       pkt_end,
`ifdef USB_RX_CRC16_EN
   output logic       rcv_error,
   output logic       crc_ok
`else
   output logic       rcv_error
`endif
);

   localparam int CW = $clog2(SAMPLES_PER_BIT);
   localparam int OW = $clog2(STUFF_LIMIT + 1);
   localparam logic [CW-1:0] PHASE_LAST   = CW'(SAMPLES_PER_BIT - 1);
   localparam logic [CW-1:0] PHASE_SAMPLE = CW'(SAMPLE_POINT);
   localparam logic [OW-1:0] ONES_LIMIT   = OW'(STUFF_LIMIT);
   localparam logic [7:0]    SYNC_WINDOW  = 8'h80;

   typedef enum logic [1:0] {IDLE, RECEIVE, EOP, ABORT} state_t;

   // ---------------------------------------------------------------
   // Input synchronizer: index 0 is D+, index 1 is D-
   // ---------------------------------------------------------------
   logic [1:0] line_raw;
   logic [1:0] line_sync;
   assign line_raw = {d_minus_in, d_plus_in};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;
         // Two-flop synchronizer per line; resets to the idle J level.
         always_ff @(posedge clk) begin
            if (rst) begin
               meta_reg <= (gi == 0) ? 1'b1 : 1'b0;
               sync_reg <= (gi == 0) ? 1'b1 : 1'b0;
            end else begin
               meta_reg <= line_raw[gi];
               sync_reg <= meta_reg;
            end
         end
         assign line_sync[gi] = sync_reg;
      end
   endgenerate

   logic dp;
   logic dm;
   assign dp = line_sync[0];
   assign dm = line_sync[1];

   // ---------------------------------------------------------------
   // Bit phase tracking and NRZI reference level
   // ---------------------------------------------------------------
   logic          dp_prev_reg;
   logic [CW-1:0] phase_cnt_reg;
   logic          prev_level_reg;
   logic          sample_en;
   logic          is_se0;
   logic          is_k;
   logic          is_j;
   logic          nrzi_bit;

   assign sample_en = (phase_cnt_reg == PHASE_SAMPLE);
   assign is_se0    = !dp && !dm;
   assign is_k      = !dp && dm;
   assign is_j      = dp;              // (1,1) is treated as J
   assign nrzi_bit  = (dp == prev_level);

   logic prev_level;
   assign prev_level = prev_level_reg;

   // Realign the sample phase on every D+ edge; track the last J/K level for NRZI.
   always_ff @(posedge clk) begin
      if (rst) begin
         dp_prev_reg    <= 1'b1;
         phase_cnt_reg  <= '0;
         prev_level_reg <= 1'b1;
      end else begin
         dp_prev_reg <= dp;
         if (dp != dp_prev_reg)
            phase_cnt_reg <= '0;
         else if (phase_cnt_reg == PHASE_LAST)
            phase_cnt_reg <= '0;
         else
            phase_cnt_reg <= phase_cnt_reg + CW'(1);
         if (sample_en && !is_se0)
            prev_level_reg <= dp;
      end
   end

   // ---------------------------------------------------------------
   // Receive FSM and byte assembly
   // ---------------------------------------------------------------
   state_t          state_reg,    state_next;
   logic [7:0]      window_reg,   window_next;
   logic [7:0]      byte_reg,     byte_next;
   logic [3:0]      bit_cnt_reg,  bit_cnt_next;
   logic [OW-1:0]   ones_cnt_reg, ones_cnt_next;
   logic [1:0]      se0_cnt_reg,  se0_cnt_next;
   logic            seen_se0_reg, seen_se0_next;
   logic [7:0]      data_reg,     data_next;
   logic            valid_reg,    valid_next;
   logic            active_reg,   active_next;
   logic            pkt_end_reg,  pkt_end_next;
   logic            error_reg,    error_next;
`ifdef USB_RX_CRC16_EN
   logic [15:0]     crc_reg,      crc_next;
   logic            pid_done_reg, pid_done_next;
   logic            crc_ok_reg,   crc_ok_next;
   logic [15:0]     crc_step;
`endif

   logic [7:0] window_shift;
   logic       byte_done;
   logic [3:0] bit_base;

   assign window_shift = {nrzi_bit, window_reg[7:1]};
   assign byte_done    = (bit_cnt_reg == 4'd8);
   // A sample landing in the same cycle as a byte hand-off starts the next byte.
   assign bit_base     = byte_done ? 4'd0 : bit_cnt_reg;
`ifdef USB_RX_CRC16_EN
   assign crc_step = {1'b0, crc_reg[15:1]} ^ ((crc_reg[0] ^ nrzi_bit) ? 16'hA001 : 16'h0000);
`endif

   // Next-state and output decode for the receive FSM.
   always_comb begin
      state_next    = state_reg;
      window_next   = window_reg;
      byte_next     = byte_reg;
      bit_cnt_next  = bit_cnt_reg;
      ones_cnt_next = ones_cnt_reg;
      se0_cnt_next  = se0_cnt_reg;
      seen_se0_next = seen_se0_reg;
      data_next     = data_reg;
      valid_next    = 1'b0;
      active_next   = active_reg;
      pkt_end_next  = 1'b0;
      error_next    = error_reg;
`ifdef USB_RX_CRC16_EN
      crc_next      = crc_reg;
      pid_done_next = pid_done_reg;
      crc_ok_next   = crc_ok_reg;
`endif
      if (!rx_enable) begin
         state_next   = IDLE;
         active_next  = 1'b0;
         window_next  = 8'hFF;
         bit_cnt_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (sample_en && !is_se0) begin
                  window_next = window_shift;
                  if (window_shift == SYNC_WINDOW) begin
                     state_next    = RECEIVE;
                     active_next   = 1'b1;
                     error_next    = 1'b0;
                     bit_cnt_next  = '0;
                     ones_cnt_next = OW'(1);
                     window_next   = 8'hFF;
`ifdef USB_RX_CRC16_EN
                     crc_next      = 16'hFFFF;
                     pid_done_next = 1'b0;
                     crc_ok_next   = 1'b0;
`endif
                  end
               end
            end
            RECEIVE: begin
               if (byte_done) begin
                  data_next    = byte_reg;
                  valid_next   = 1'b1;
                  bit_cnt_next = '0;
`ifdef USB_RX_CRC16_EN
                  pid_done_next = 1'b1;
`endif
               end
               if (sample_en) begin
                  if (is_se0) begin
                     state_next   = EOP;
                     se0_cnt_next = 2'd1;
                  end else if (ones_cnt_reg == ONES_LIMIT) begin
                     // Stuffed bit position: must be 0 and is discarded.
                     ones_cnt_next = '0;
                     if (nrzi_bit) begin
                        error_next    = 1'b1;
                        active_next   = 1'b0;
                        seen_se0_next = 1'b0;
                        state_next    = ABORT;
                     end
                  end else begin
                     byte_next     = {nrzi_bit, byte_reg[7:1]};
                     bit_cnt_next  = bit_base + 4'd1;
                     ones_cnt_next = nrzi_bit ? (ones_cnt_reg + OW'(1)) : '0;
`ifdef USB_RX_CRC16_EN
                     if (pid_done_reg || byte_done)
                        crc_next = crc_step;
`endif
                  end
               end
            end
            EOP: begin
               if (sample_en) begin
                  if (is_se0) begin
                     if (se0_cnt_reg == 2'd1) begin
                        se0_cnt_next = 2'd2;
                     end else begin
                        error_next    = 1'b1;
                        active_next   = 1'b0;
                        seen_se0_next = 1'b1;
                        state_next    = ABORT;
                     end
                  end else if (is_k) begin
                     error_next    = 1'b1;
                     active_next   = 1'b0;
                     seen_se0_next = 1'b0;
                     state_next    = ABORT;
                  end else if (is_j) begin
                     active_next = 1'b0;
                     state_next  = IDLE;
                     if (bit_cnt_reg == 4'd0) begin
                        pkt_end_next = 1'b1;
`ifdef USB_RX_CRC16_EN
                        crc_ok_next  = (crc_reg == 16'hB001);
`endif
                     end else begin
                        error_next = 1'b1;
                     end
                  end
               end
            end
            ABORT: begin
               active_next = 1'b0;
               if (sample_en) begin
                  if (is_j && seen_se0_reg)
                     state_next = IDLE;
                  seen_se0_next = is_se0;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Register the FSM state, datapath and all outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         window_reg   <= 8'hFF;
         byte_reg     <= '0;
         bit_cnt_reg  <= '0;
         ones_cnt_reg <= '0;
         se0_cnt_reg  <= '0;
         seen_se0_reg <= 1'b0;
         data_reg     <= '0;
         valid_reg    <= 1'b0;
         active_reg   <= 1'b0;
         pkt_end_reg  <= 1'b0;
         error_reg    <= 1'b0;
`ifdef USB_RX_CRC16_EN
         crc_reg      <= 16'hFFFF;
         pid_done_reg <= 1'b0;
         crc_ok_reg   <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         window_reg   <= window_next;
         byte_reg     <= byte_next;
         bit_cnt_reg  <= bit_cnt_next;
         ones_cnt_reg <= ones_cnt_next;
         se0_cnt_reg  <= se0_cnt_next;
         seen_se0_reg <= seen_se0_next;
         data_reg     <= data_next;
         valid_reg    <= valid_next;
         active_reg   <= active_next;
         pkt_end_reg  <= pkt_end_next;
         error_reg    <= error_next;
`ifdef USB_RX_CRC16_EN
         crc_reg      <= crc_next;
         pid_done_reg <= pid_done_next;
         crc_ok_reg   <= crc_ok_next;
`endif
      end
   end

   assign rcv_data   = data_reg;
   assign rcv_valid  = valid_reg;
   assign rcv_active = active_reg;
   assign pkt_end    = pkt_end_reg;
   assign rcv_error  = error_reg;
`ifdef USB_RX_CRC16_EN
   assign crc_ok     = crc_ok_reg;
`endif

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Testbench for usb_rx_line_decoder: builds wire-level packets (stuffing, NRZI,
// SYNC, EOP) from byte lists and compares the delivered bytes and status flags.
// Define USB_RX_CRC16_EN to also exercise the CRC16 checker.
module tb_usb_rx_line_decoder;

   localparam logic [1:0] SYM_J   = 2'b10;   // {D+, D-}
   localparam logic [1:0] SYM_K   = 2'b01;
   localparam logic [1:0] SYM_SE0 = 2'b00;

   logic       clk = 1'b0;
   logic       rst;
   logic       d_plus_in;
   logic       d_minus_in;
   logic       rx_enable;
   logic [7:0] rcv_data;
   logic       rcv_valid;
   logic       rcv_active;
   logic       pkt_end;
   logic       rcv_error;
`ifdef USB_RX_CRC16_EN
   logic       crc_ok;
`endif

   usb_rx_line_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .d_plus_in  (d_plus_in),
      .d_minus_in (d_minus_in),
      .rx_enable  (rx_enable),
      .rcv_data   (rcv_data),
      .rcv_valid  (rcv_valid),
      .rcv_active (rcv_active),
      .pkt_end    (pkt_end),
`ifdef USB_RX_CRC16_EN
      .rcv_error  (rcv_error),
      .crc_ok     (crc_ok)
`else
      .rcv_error  (rcv_error)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Monitor: collect delivered bytes and strobe statistics
   logic [7:0] got_q[$];
   int pkt_cnt     = 0;
   int active_cnt  = 0;
   int overlap_cnt = 0;
   always @(negedge clk) begin
      if (rcv_valid) got_q.push_back(rcv_data);
      if (pkt_end) pkt_cnt++;
      if (rcv_active) active_cnt++;
      if (rcv_valid && pkt_end) overlap_cnt++;
   end

   // Frame under construction
   bit         bits_q[$];
   logic [7:0] exp_q[$];
   logic [1:0] sym_q[$];
   int         data_start;
   bit         jit_tog = 1'b0;
   logic       err_mid;
   logic       act_mid;
   int         cut_valid;
   int         cut_pkt;
   int         base_v, base_p, base_a;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic new_frame();
      bits_q.delete();
      exp_q.delete();
   endtask

   task automatic add_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) bits_q.push_back(b[i]);
      exp_q.push_back(b);
   endtask

   task automatic add_bit(input bit b);
      bits_q.push_back(b);
   endtask

   task automatic snapshot();
      base_v = got_q.size();
      base_p = pkt_cnt;
      base_a = active_cnt;
   endtask

   // Wire encoding: idle J, SYNC, stuffed NRZI data, EOP, idle J
   task automatic build_frame(input bit do_stuff, input int eop_len);
      bit level;
      int ones;
      sym_q.delete();
      repeat (3) sym_q.push_back(SYM_J);
      for (int i = 0; i < 8; i++) sym_q.push_back((i % 2 == 0 || i == 7) ? SYM_K : SYM_J);
      level = 1'b0;
      ones  = 1;
      data_start = sym_q.size();
      for (int i = 0; i < bits_q.size(); i++) begin
         if (!bits_q[i]) level = ~level;
         sym_q.push_back(level ? SYM_J : SYM_K);
         ones = bits_q[i] ? ones + 1 : 0;
         if (do_stuff && ones == 6) begin
            level = ~level;
            sym_q.push_back(level ? SYM_J : SYM_K);
            ones = 0;
         end
      end
      repeat (eop_len) sym_q.push_back(SYM_SE0);
      repeat (4) sym_q.push_back(SYM_J);
   endtask

   // cut_kind: 0 none, 1 drop rx_enable, 2 pulse rst, at data symbol cut_off
   task automatic send_frame(input bit do_stuff, input bit jitter, input int eop_len,
                             input int cut_off, input int cut_kind);
      int per;
      build_frame(do_stuff, eop_len);
      for (int i = 0; i < sym_q.size(); i++) begin
         per = jitter ? (jit_tog ? 9 : 7) : 8;
         jit_tog = ~jit_tog;
         if (i == data_start + 2) begin
            err_mid = rcv_error;
            act_mid = rcv_active;
         end
         {d_plus_in, d_minus_in} = sym_q[i];
         if (cut_kind != 0 && i == data_start + cut_off) begin
            if (cut_kind == 1) rx_enable = 1'b0;
            else rst = 1'b1;
            tick(1);
            rst = 1'b0;
            cut_valid = got_q.size();
            cut_pkt   = pkt_cnt;
            if (cut_kind == 1) begin
               check("en_drop_active", rcv_active, 0);
            end else begin
               check("rst_mid_data", rcv_data, 0);
               check("rst_mid_valid", rcv_valid, 0);
               check("rst_mid_active", rcv_active, 0);
               check("rst_mid_pkt_end", pkt_end, 0);
               check("rst_mid_error", rcv_error, 0);
            end
            tick(per - 1);
         end else begin
            tick(per);
         end
      end
      rx_enable = 1'b1;
   endtask

   task automatic check_good(input string tag);
      logic [31:0] obs;
      check($sformatf("%s_nbytes", tag), got_q.size() - base_v, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (base_v + i < got_q.size()) ? {24'd0, got_q[base_v + i]} : 32'hDEAD;
         check($sformatf("%s_byte%0d", tag, i), obs, {24'd0, exp_q[i]});
      end
      check($sformatf("%s_pkt_end", tag), pkt_cnt - base_p, 1);
      check($sformatf("%s_error", tag), rcv_error, 0);
      check($sformatf("%s_active_end", tag), rcv_active, 0);
      check($sformatf("%s_active_seen", tag), (active_cnt - base_a) > 0, 1);
   endtask

`ifdef USB_RX_CRC16_EN
   function automatic logic [15:0] crc16_over(input int from, input int to);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = from; i < to; i++)
         c = (c >> 1) ^ (((c[0] ^ bits_q[i]) != 1'b0) ? 16'hA001 : 16'h0000);
      return c;
   endfunction
`endif

   initial begin
      int nb;
      rst = 1'b1;
      rx_enable = 1'b1;
      {d_plus_in, d_minus_in} = SYM_J;
      @(posedge clk);
      #1;
      tick(3);
      check("reset_data", rcv_data, 0);
      check("reset_valid", rcv_valid, 0);
      check("reset_active", rcv_active, 0);
      check("reset_pkt_end", pkt_end, 0);
      check("reset_error", rcv_error, 0);
      rst = 1'b0;
      tick(20);

      // Basic packet: PID C3, data AA, single-bit SE0
      new_frame(); add_byte(8'hC3); add_byte(8'hAA);
      snapshot();
      send_frame(1'b1, 1'b0, 1, 0, 0);
      check_good("t1");

      // FF with stuffing
      new_frame(); add_byte(8'hC3); add_byte(8'hFF);
      snapshot();
      send_frame(1'b1, 1'b0, 2, 0, 0);
      check_good("t2_stuffed");
      check("t2_rcv_data", rcv_data, 8'hFF);

      // FF without the stuffed 0
      new_frame(); add_byte(8'hC3); add_byte(8'hFF);
      snapshot();
      send_frame(1'b0, 1'b0, 2, 0, 0);
      check("t2_nostuff_error", rcv_error, 1);
      check("t2_nostuff_pkt_end", pkt_cnt - base_p, 0);
      check("t2_nostuff_active", rcv_active, 0);

      // SE0 after 4 bits of the second byte
      new_frame(); add_byte(8'hC3);
      add_bit(1); add_bit(0); add_bit(1); add_bit(0);
      snapshot();
      send_frame(1'b1, 1'b0, 2, 0, 0);
      check("t3_error", rcv_error, 1);
      check("t3_active", rcv_active, 0);
      check("t3_pkt_end", pkt_cnt - base_p, 0);
      check("t3_nbytes", got_q.size() - base_v, 1);

      // Clean packet afterwards clears the error at SYNC
      new_frame(); add_byte(8'h4B); add_byte(8'($urandom)); add_byte(8'($urandom));
      snapshot();
      send_frame(1'b1, 1'b0, 2, 0, 0);
      check("t3_err_cleared_at_sync", err_mid, 0);
      check("t3_active_after_sync", act_mid, 1);
      check_good("t3_clean");

      // Bit-period jitter 7/9
      new_frame(); add_byte(8'hC3); add_byte(8'hFF); add_byte(8'($urandom)); add_byte(8'h7E);
      snapshot();
      send_frame(1'b1, 1'b1, 2, 0, 0);
      check_good("t4_jitter");

      // rx_enable dropped mid-byte
      new_frame(); add_byte(8'hC3); add_byte(8'hFF); add_byte(8'hFF);
      snapshot();
      send_frame(1'b1, 1'b0, 2, 12, 1);
      check("t5_en_no_valid", got_q.size() - cut_valid, 0);
      check("t5_en_no_pkt_end", pkt_cnt - cut_pkt, 0);
      check("t5_en_error_held", rcv_error, 0);
      tick(16);

      // rst pulse mid-packet
      new_frame(); add_byte(8'hC3); add_byte(8'hFF); add_byte(8'hFF);
      snapshot();
      send_frame(1'b1, 1'b0, 2, 12, 2);
      check("t5_rst_no_valid", got_q.size() - cut_valid, 0);
      check("t5_rst_no_pkt_end", pkt_cnt - cut_pkt, 0);
      tick(16);

      // Randomized packets
      for (int p = 0; p < 8; p++) begin
         new_frame();
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++)
            add_byte(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
         snapshot();
         send_frame(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 2), 0, 0);
         check_good($sformatf("rnd%0d", p));
      end

`ifdef USB_RX_CRC16_EN
      begin
         logic [15:0] c;
         new_frame(); add_byte(8'hC3); add_byte(8'h00); add_byte(8'h01);
         c = ~crc16_over(8, bits_q.size());
         add_byte(c[7:0]); add_byte(c[15:8]);
         snapshot();
         send_frame(1'b1, 1'b0, 2, 0, 0);
         check_good("t6_crc_good");
         check("t6_crc_ok_good", crc_ok, 1);
         new_frame(); add_byte(8'hC3); add_byte(8'h00); add_byte(8'h03);
         add_byte(c[7:0]); add_byte(c[15:8]);
         snapshot();
         send_frame(1'b1, 1'b0, 2, 0, 0);
         check_good("t6_crc_bad");
         check("t6_crc_ok_bad", crc_ok, 0);
      end
`endif

      check("no_valid_pkt_end_overlap", overlap_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
